uart_hex_reporter: RTL
======================

// Module: uart_hex_reporter
// PURPOSE
//  Host-bound path: accepts 8-bit values on a valid/ready strobe, buffers them in a small FIFO and
//  sends each one over UART 8N1 as ASCII hex text: two uppercase digits, then optionally CR LF.
//  Pairs with the host-to-board receive/7-segment display path, so the board can report values as readable text.
// PARAMETERS
//  CLKS_PER_BIT  217  clocks per UART bit (25 MHz / 115200)
//  FIFO_DEPTH    4    entries in the input FIFO; must be a power of 2 and >= 2
//  APPEND_CRLF   1    1: send "HH\r\n" for each value; 0: send "HH" only
// PORTS
//  i_Clk       in   1  system clock
//  i_Rst_L     in   1  asynchronous reset, active low
//  i_DV        in   1  input value valid, one-cycle strobe
//  i_Byte      in   8  value to report; sampled when i_DV=1 and o_Ready=1
//  o_Ready     out  1  FIFO not full
//  o_Drop      out  1  one-cycle pulse when i_DV=1 arrives while o_Ready=0 (the value is discarded)
//  o_Busy      out  1  FIFO not empty, or a character is in progress
//  o_UART_TX   out  1  serial line; idles high
// BEHAVIOUR
//  Reset values: o_UART_TX=1, o_Ready=1, o_Busy=0, o_Drop=0; FIFO is empty; FSM is in IDLE.
//  All outputs are registered.
//  Line format: start bit 0, then 8 data bits LSB first, then stop bit 1.
//   Each bit is held for exactly CLKS_PER_BIT clocks.
//  Gap between characters: exactly 1 clock of line-high after the stop bit, then the next start bit.
//  Latency: if idle, o_UART_TX falls on the 2nd rising edge after the edge that accepted the value.
//  FIFO write: occurs when i_DV & o_Ready.
//   o_Ready is registered from the count; it is low when count==FIFO_DEPTH.
//   A write while full is dropped, even if a pop happens in the same cycle.
//   A simultaneous push and pop (when not full) leaves count unchanged.
//  Formatter FSM states:
//   IDLE -> POP when the FIFO is not empty. POP reads the head into a hold register.
//   POP -> HI. HI sends the ASCII of byte[7:4] and waits for core done.
//   HI -> LO. LO sends the ASCII of byte[3:0] and waits for core done.
//   LO -> CR if APPEND_CRLF, otherwise IDLE.
//   CR sends 8'h0D and goes to LF on core done. LF sends 8'h0A and goes to IDLE on core done.
//   IDLE re-checks the FIFO in the same cycle, so back-to-back values keep the 1-clock character gap.
//  Nibble to ASCII: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10) ('A'-'F'). Uppercase only.
//  o_Busy = (count!=0) | (state!=IDLE), registered.
//  Reset mid-frame: o_UART_TX returns to 1 asynchronously.
//   The partial character, the hold register and the FIFO contents are discarded.
//   No output follows reset release until a new value is accepted.
//  FIFO pointers wrap modulo FIFO_DEPTH. The count is (log2(FIFO_DEPTH)+1) bits wide.
// STRUCTURE
//  Shared package uart_pkg holds:
//   ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41
//   function nibble_to_ascii
//   the formatter state encoding (IDLE, POP, HI, LO, CR, LF)
//  Sub-module uart_tx_core: a single-byte serializer.
//   Ports: i_Clk, i_Rst_L, i_Start, i_Byte; outputs o_TX, o_Active, o_Done.
//   o_Done is a one-cycle pulse at the end of the stop bit.
//   The serializer is instantiated once. The FIFO and formatter FSM are inline in uart_hex_reporter.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
//  1. Reset only -> o_UART_TX=1, o_Ready=1, o_Busy=0, o_Drop=0; line stays high for 100 clocks.
//  2. Send 8'h3A -> line decodes 8'h33, 8'h41, 8'h0D, 8'h0A.
//     Each frame is 40 clocks; the gaps are 1 clock; o_Busy falls after the final stop bit.
//  3. Send 8'h09 then 8'hF0 -> line decodes "09\r\n" then "F0\r\n". Checks digit/letter edges and ordering.
//  4. Six i_DV strobes back-to-back (8'h01..8'h06) -> 01..05 accepted; 06 dropped with one o_Drop pulse.
//     o_Ready is low while full; the line outputs 01..05 in order.
//  5. Assert i_Rst_L=0 in the middle of the data bits of the 2nd character of 8'hAB
//     -> o_UART_TX=1 immediately; FIFO empty. After release, the line stays high with no stray frames.
//  6. APPEND_CRLF=0, send 8'hC4 -> exactly two frames, 8'h43 then 8'h34; then idle, with o_Busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex reporter: ASCII constants, formatter
// state encoding and the nibble-to-hex-digit helper.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        HI,
        LO,
        CR,
        LF
    } fmt_state_t;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end else begin
            return ASCII_A + {4'h0, nib - 4'd10};
        end
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-byte UART 8N1 serializer. o_Done pulses for one clock right after the
// stop bit completes, in the cycle where a new i_Start can already be accepted.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic [7:0] i_Byte,
    output logic       o_TX,
    output logic       o_Active,
    output logic       o_Done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift;

    // bit_idx counts bit periods already finished; shifting in ones makes the
    // ninth period come out as the stop bit without a separate case.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_TX     <= 1'b1;
            o_Active <= 1'b0;
            o_Done   <= 1'b0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            o_Done <= 1'b0;
            if (!o_Active) begin
                if (i_Start) begin
                    o_Active <= 1'b1;
                    o_TX     <= 1'b0;
                    shift    <= i_Byte;
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                end
            end else if (clk_cnt != CNT_MAX) begin
                clk_cnt <= clk_cnt + 1'b1;
            end else begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    o_Active <= 1'b0;
                    o_Done   <= 1'b1;
                    o_TX     <= 1'b1;
                end else begin
                    o_TX    <= shift[0];
                    shift   <= {1'b1, shift[7:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_hex_reporter.sv
// Buffers incoming bytes in a small FIFO and reports each one over UART as two
// uppercase hex digits, optionally followed by CR LF.
module uart_hex_reporter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4,
    parameter int APPEND_CRLF  = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_DV,
    input  logic [7:0] i_Byte,
    output logic       o_Ready,
    output logic       o_Drop,
    output logic       o_Busy,
    output logic       o_UART_TX
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [7:0]       head;
    logic [7:0]       hold;
    logic             push;
    logic             pop;

    fmt_state_t state;
    fmt_state_t state_next;
    logic       char_done;
    logic       tx_start;
    logic [7:0] tx_char;
    logic       tx_active;
    logic       tx_done;

    assign push = i_DV & o_Ready;
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[wr_ptr] <= i_Byte;
        end
    end

    // At the end of a report the FSM pops the next value directly instead of
    // passing through IDLE/POP, which keeps the one-clock gap between values.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_start   = 1'b0;
        tx_char    = 8'h00;
        char_done  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !tx_active) begin
                    state_next = POP;
                end
            end
            POP: begin
                pop        = 1'b1;
                tx_start   = 1'b1;
                tx_char    = nibble_to_ascii(head[7:4]);
                state_next = HI;
            end
            HI: begin
                if (tx_done) begin
                    tx_start   = 1'b1;
                    tx_char    = nibble_to_ascii(hold[3:0]);
                    state_next = LO;
                end
            end
            LO: begin
                if (tx_done) begin
                    if (APPEND_CRLF != 0) begin
                        tx_start   = 1'b1;
                        tx_char    = ASCII_CR;
                        state_next = CR;
                    end else begin
                        char_done = 1'b1;
                    end
                end
            end
            CR: begin
                if (tx_done) begin
                    tx_start   = 1'b1;
                    tx_char    = ASCII_LF;
                    state_next = LF;
                end
            end
            LF: begin
                if (tx_done) begin
                    char_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (char_done) begin
            if (count != '0) begin
                pop        = 1'b1;
                tx_start   = 1'b1;
                tx_char    = nibble_to_ascii(head[7:4]);
                state_next = HI;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= IDLE;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            hold    <= '0;
            o_Ready <= 1'b1;
            o_Drop  <= 1'b0;
            o_Busy  <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            o_Ready <= (count_next != FULL_COUNT);
            o_Drop  <= i_DV & ~o_Ready;
            o_Busy  <= (count_next != '0) | (state_next != IDLE);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= head;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_core (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Start (tx_start),
        .i_Byte  (tx_char),
        .o_TX    (o_UART_TX),
        .o_Active(tx_active),
        .o_Done  (tx_done)
    );

endmodule
